// File: rtl/serial_adder.sv
// Digit-serial adder: {cout,s} = a + b + cin, DIGIT bits per clock, done pulses WIDTH/DIGIT cycles after acceptance.
// START is taken only while ready=1 (otherwise ignored); optional signed-overflow output via SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsum;

  assign ready = (state == IDLE);
  assign last  = (cnt == LAST);
  assign dsum  = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

  // New digit enters at the top; after N digits the register holds the whole sum in order.
  assign res_next = WIDTH'({dsum[DIGIT-1:0], res_sh} >> DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      cout   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= cin;
        res_sh <= '0;
        cnt    <= '0;
      end else if (state == BUSY) begin
        a_sh   <= a_sh >> DIGIT;
        b_sh   <= b_sh >> DIGIT;
        carry  <= dsum[DIGIT];
        res_sh <= res_next;
        cnt    <= cnt + 1'b1;
        if (last) begin
          s    <= res_next;
          cout <= dsum[DIGIT];
          done <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          // Operands' sign bits agree but the result's sign differs.
          ovf  <= (a_sh[DIGIT-1] == b_sh[DIGIT-1]) && (dsum[DIGIT-1] != a_sh[DIGIT-1]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: DIGIT=4 main instance plus DIGIT=1 and DIGIT=16 instances, checked against plain arithmetic.
module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start4, start1, start16;
  logic [15:0] a, b;
  logic        cin;
  logic        ready4, ready1, ready16;
  logic [15:0] s4, s1, s16;
  logic        cout4, cout1, cout16;
  logic        done4, done1, done16;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf4, ovf1, ovf16;
`endif

  int vectors = 0;
  int errs    = 0;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin),
    .ready(ready4), .s(s4), .cout(cout4),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf4),
`endif
    .done(done4));

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .cin(cin),
    .ready(ready1), .s(s1), .cout(cout1),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf1),
`endif
    .done(done1));

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a), .b(b), .cin(cin),
    .ready(ready16), .s(s16), .cout(cout16),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf16),
`endif
    .done(done16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation on all three instances at once; results compared with A+B+CIN.
  task automatic op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    logic [16:0] ref_sum;
    int          sa;
    logic        ref_ovf;
    int          lat4, lat1, lat16;
    ref_sum = 17'(va) + 17'(vb) + 17'(vc);
    sa      = int'($signed(va)) + int'($signed(vb)) + int'(vc);
    ref_ovf = (sa > 32767) || (sa < -32768);
    a = va; b = vb; cin = vc;
    start4 = 1'b1; start1 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat4 = 0; lat1 = 0; lat16 = 0;
    for (int c = 1; c <= 24 && (lat4 == 0 || lat1 == 0 || lat16 == 0); c++) begin
      @(posedge clk); #1;
      if (lat4 != 0 && c == lat4 + 1) chk("d4_done_pulse", done4, 0);
      if (lat4 == 0) begin
        if (done4) begin
          lat4 = c;
          chk("d4_sum", {cout4, s4}, ref_sum);
          chk("d4_ready_with_done", ready4, 1);
`ifdef SERIAL_ADDER_OVF_EN
          chk("d4_ovf", ovf4, ref_ovf);
`endif
        end else begin
          chk("d4_busy_ready", ready4, 0);
        end
      end
      if (lat1 == 0 && done1) begin
        lat1 = c;
        chk("d1_sum", {cout1, s1}, ref_sum);
`ifdef SERIAL_ADDER_OVF_EN
        chk("d1_ovf", ovf1, ref_ovf);
`endif
      end
      if (lat16 == 0 && done16) begin
        lat16 = c;
        chk("d16_sum", {cout16, s16}, ref_sum);
`ifdef SERIAL_ADDER_OVF_EN
        chk("d16_ovf", ovf16, ref_ovf);
`endif
      end
    end
    chk("d4_latency", lat4, 4);
    chk("d1_latency", lat1, 16);
    chk("d16_latency", lat16, 1);
    @(posedge clk); #1;
    chk("done_cleared", {done4, done1, done16}, 3'b000);
    chk("all_ready", {ready4, ready1, ready16}, 3'b111);
  endtask

  initial begin
    logic [16:0] q_sum[$];
    logic [16:0] exp_sum;
    int          seen;

    rst_n = 1'b0;
    start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready4, 1);
    chk("rst_done", done4, 0);
    chk("rst_s", s4, 0);
    chk("rst_cout", cout4, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf4, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(16'h1234, 16'h4321, 1'b0);
    chk("basic_s", s4, 16'h5555);
    chk("basic_cout", cout4, 0);
    op(16'hFFFF, 16'h0001, 1'b0);
    chk("carry_chain_b", {cout4, s4}, 17'h10000);
    op(16'hFFFF, 16'h0000, 1'b1);
    chk("carry_chain_cin", {cout4, s4}, 17'h10000);
`ifdef SERIAL_ADDER_OVF_EN
    op(16'h7FFF, 16'h0001, 1'b0);
    chk("ovf_pos_s", {cout4, s4}, 17'h08000);
    chk("ovf_pos", ovf4, 1);
    op(16'h8000, 16'h8000, 1'b0);
    chk("ovf_neg_s", {cout4, s4}, 17'h10000);
    chk("ovf_neg", ovf4, 1);
    op(16'h1234, 16'h4321, 1'b0);
    chk("ovf_none", ovf4, 0);
`endif

    // START held high: acceptances every 5th edge, each result from its own acceptance operands.
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    start4 = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk);
      if (t % 5 == 0) q_sum.push_back(17'(a) + 17'(b) + 17'(cin));
      #1;
      chk("cont_done", done4, (t % 5 == 4));
      chk("cont_ready", ready4, (t % 5 == 4));
      if (t % 5 == 4 && q_sum.size() > 0) begin
        exp_sum = q_sum.pop_front();
        chk("cont_sum", {cout4, s4}, exp_sum);
      end
      if (t < 29) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      end else begin
        start4 = 1'b0;
      end
    end

    // Abort mid-operation with reset.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("abort_busy", ready4, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready4, 1);
    chk("abort_s", s4, 0);
    chk("abort_cout", cout4, 0);
    chk("abort_done", done4, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done4) seen++;
    end
    chk("abort_no_done", seen, 0);
    op(16'h0002, 16'h0003, 1'b0);
    chk("after_abort_s", s4, 16'h0005);

    for (int i = 0; i < 1000; i++) begin
      op(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
